// File: rtl/result_frame_tx_if.sv
// result_frame_tx_if: result inputs, control strobes and serial status of the frame transmitter
interface result_frame_tx_if;
  logic       clear;
  logic       send;
  logic [7:0] digit0;
  logic [7:0] digit1;
  logic [7:0] count1;
  logic [7:0] count0;
  logic       warning;
  logic       selection;
  logic       mode;
  logic       tx;
  logic       busy;
  logic       done;
  logic       overrun;
  modport master (
    output clear, send, digit0, digit1, count1, count0, warning, selection, mode,
    input  tx, busy, done, overrun
  );
  modport slave (
    input  clear, send, digit0, digit1, count1, count0, warning, selection, mode,
    output tx, busy, done, overrun
  );
endinterface

// File: rtl/result_frame_tx.sv
// result_frame_tx: snapshots classifier results and ships them as a 6-byte 8N1 UART frame
module result_frame_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input logic              CLK,
  input logic              RST_N,
  result_frame_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [2:0]      byte_idx;
  logic [5:0][7:0] shadow;
  logic [7:0]      b1;
  logic [7:0]      b4;
  logic            tick;
  always_comb begin
    b1   = {5'b0, bus.selection, bus.mode, bus.warning};
    b4   = {bus.count1[3:0], bus.count0[3:0]};
    tick = cnt == LAST;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shadow      <= '0;
      bus.tx      <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      bus.tx      <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      cnt      <= (tick || state == IDLE) ? '0 : cnt + 1'b1;
      if (bus.send && bus.busy) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (bus.send) begin
          // checksum is taken from the same snapshot that is latched
          shadow   <= {HEADER ^ b1 ^ bus.digit0 ^ bus.digit1 ^ b4, b4, bus.digit1, bus.digit0, b1, HEADER};
          byte_idx <= '0;
          state    <= START;
          bus.tx   <= 1'b0;
          bus.busy <= 1'b1;
        end
        START: if (tick) begin
          state   <= DATA;
          bit_idx <= '0;
          bus.tx  <= shadow[byte_idx][0];
        end
        DATA: if (tick) begin
          bit_idx <= bit_idx + 3'd1;
          state   <= bit_idx == 3'd7 ? STOP : DATA;
          bus.tx  <= bit_idx == 3'd7 ? 1'b1 : shadow[byte_idx][bit_idx + 3'd1];
        end
        STOP: if (tick) begin
          if (byte_idx < 3'd5) begin
            byte_idx <= byte_idx + 3'd1;
            state    <= START;
            bus.tx   <= 1'b0;
          end else begin
            byte_idx <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_frame_tx.sv
// tb_result_frame_tx: randomized and directed checks of the result frame transmitter against a frame model
module tb_result_frame_tx;
  localparam int C = 4;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  logic rtx[256];
  logic rbusy[256];
  logic rdone[256];
  logic rovr[256];
  result_frame_tx_if bus();
  result_frame_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;

  function automatic logic [5:0][7:0] frame_of(input logic [7:0] d0, d1, c1, c0, input logic w, s, m);
    logic [5:0][7:0] f;
    f[0] = 8'hA5;
    f[1] = {5'b0, s, m, w};
    f[2] = d0;
    f[3] = d1;
    f[4] = {c1[3:0], c0[3:0]};
    f[5] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4];
    return f;
  endfunction

  // serial line level t cycles after the frame starts: start, 8 data LSB first, stop
  function automatic logic exp_bit(input logic [5:0][7:0] f, input int t);
    int pos;
    pos = (t / C) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return f[t / (10 * C)][pos - 1];
  endfunction

  task automatic set_in(input logic [7:0] d0, d1, c1, c0, input logic w, s, m);
    bus.digit0 = d0; bus.digit1 = d1; bus.count1 = c1; bus.count0 = c0;
    bus.warning = w; bus.selection = s; bus.mode = m;
  endtask

  task automatic pulse_send;
    bus.send = 1'b1;
    @(posedge CLK); #1;
    bus.send = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      rtx[i] = bus.tx; rbusy[i] = bus.busy; rdone[i] = bus.done; rovr[i] = bus.overrun;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1;
    checks += 4;
    if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", bus.tx); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks += 2;
    if (bus.tx !== 1'b1) begin errors++; $display("FAIL idle_tx got %b exp 1", bus.tx); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic;
    logic [5:0][7:0] f;
    int nb, nd;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    f = frame_of(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    pulse_send;
    capture(242);
    nb = 0; nd = 0;
    for (int i = 0; i < 242; i++) begin
      nb += int'(rbusy[i]); nd += int'(rdone[i]);
      checks++;
      if (rtx[i] !== (i < 240 ? exp_bit(f, i) : 1'b1)) begin
        errors++; $display("FAIL basic_tx[%0d] got %b exp %b", i, rtx[i], i < 240 ? exp_bit(f, i) : 1'b1);
      end
    end
    checks += 4;
    if (nb != 240) begin errors++; $display("FAIL basic_busy_len got %0d exp 240", nb); end
    if (rbusy[239] !== 1'b1 || rbusy[240] !== 1'b0) begin errors++; $display("FAIL basic_busy_edge got %b%b exp 10", rbusy[239], rbusy[240]); end
    if (rdone[240] !== 1'b1) begin errors++; $display("FAIL basic_done_at_241 got %b exp 1", rdone[240]); end
    if (nd != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_input_change;
    logic [5:0][7:0] f;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    f = frame_of(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    pulse_send;
    fork
      capture(241);
      begin repeat (19) @(posedge CLK); #1; set_in(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); end
    join
    for (int i = 0; i < 240; i++) begin
      checks++;
      if (rtx[i] !== exp_bit(f, i)) begin errors++; $display("FAIL change_tx[%0d] got %b exp %b", i, rtx[i], exp_bit(f, i)); end
    end
    checks++;
    if (rdone[240] !== 1'b1) begin errors++; $display("FAIL change_done got %b exp 1", rdone[240]); end
  endtask

  task automatic test_overrun;
    logic [5:0][7:0] f;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    f = frame_of(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    pulse_send;
    fork
      capture(246);
      begin repeat (49) @(posedge CLK); #1; bus.send = 1'b1; @(posedge CLK); #1; bus.send = 1'b0; end
    join
    for (int i = 0; i < 246; i++) begin
      checks += 2;
      if (rtx[i] !== (i < 240 ? exp_bit(f, i) : 1'b1)) begin errors++; $display("FAIL ovr_tx[%0d] got %b exp %b", i, rtx[i], i < 240 ? exp_bit(f, i) : 1'b1); end
      if (rovr[i] !== (i >= 50)) begin errors++; $display("FAIL ovr_flag[%0d] got %b exp %b", i, rovr[i], i >= 50); end
    end
    checks++;
    if (rdone[240] !== 1'b1) begin errors++; $display("FAIL ovr_done got %b exp 1", rdone[240]); end
    bus.clear = 1'b1;
    @(posedge CLK); #1;
    bus.clear = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.overrun); end
  endtask

  task automatic test_back_to_back;
    logic [5:0][7:0] f1, f2;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    f1 = frame_of(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    f2 = frame_of(8'h07, 8'h0B, 8'd3, 8'd5, 1'b1, 1'b1, 1'b0);
    pulse_send;
    capture(240);
    for (int i = 0; i < 240; i++) begin
      checks++;
      if (rtx[i] !== exp_bit(f1, i)) begin errors++; $display("FAIL b2b_first_tx[%0d] got %b exp %b", i, rtx[i], exp_bit(f1, i)); end
    end
    checks += 2;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", bus.done); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_gap got %b exp 0", bus.busy); end
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b1, 1'b1, 1'b0);
    pulse_send;
    capture(241);
    for (int i = 0; i < 240; i++) begin
      checks += 2;
      if (rtx[i] !== exp_bit(f2, i)) begin errors++; $display("FAIL b2b_second_tx[%0d] got %b exp %b", i, rtx[i], exp_bit(f2, i)); end
      if (rovr[i] !== 1'b0) begin errors++; $display("FAIL b2b_overrun[%0d] got %b exp 0", i, rovr[i]); end
    end
    checks++;
    if (rdone[240] !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", rdone[240]); end
  endtask

  task automatic test_random;
    logic [5:0][7:0] f;
    logic [7:0] d0, d1, c1, c0;
    logic w, s, m;
    int at;
    for (int r = 0; r < 4; r++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); c1 = 8'($urandom); c0 = 8'($urandom);
      w = 1'($urandom); s = 1'($urandom); m = 1'($urandom);
      set_in(d0, d1, c1, c0, w, s, m);
      f = frame_of(d0, d1, c1, c0, w, s, m);
      at = $urandom_range(1, 200);
      pulse_send;
      fork
        capture(241);
        begin
          repeat (at) @(posedge CLK);
          #1;
          set_in(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
      join
      for (int i = 0; i < 240; i++) begin
        checks++;
        if (rtx[i] !== exp_bit(f, i)) begin errors++; $display("FAIL rand%0d_tx[%0d] got %b exp %b", r, i, rtx[i], exp_bit(f, i)); end
      end
      checks++;
      if (rdone[240] !== 1'b1) begin errors++; $display("FAIL rand%0d_done got %b exp 1", r, rdone[240]); end
    end
  endtask

  task automatic test_async_reset;
    int nd, nlow, nbusy;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    pulse_send;
    repeat (9) @(posedge CLK);
    #1;
    checks += 2;
    if (bus.tx !== 1'b0) begin errors++; $display("FAIL arst_pre_tx got %b exp 0", bus.tx); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b exp 1", bus.busy); end
    #2 RST_N = 1'b0;
    #1;
    checks += 2;
    if (bus.tx !== 1'b1) begin errors++; $display("FAIL arst_tx got %b exp 1", bus.tx); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", bus.busy); end
    #2 RST_N = 1'b1;
    nd = 0; nlow = 0; nbusy = 0;
    repeat (300) begin
      @(posedge CLK); #1;
      nd += int'(bus.done); nlow += int'(!bus.tx); nbusy += int'(bus.busy);
    end
    checks += 3;
    if (nd != 0) begin errors++; $display("FAIL arst_done_after got %0d exp 0", nd); end
    if (nlow != 0) begin errors++; $display("FAIL arst_tx_low_after got %0d exp 0", nlow); end
    if (nbusy != 0) begin errors++; $display("FAIL arst_busy_after got %0d exp 0", nbusy); end
  endtask

  task automatic test_clear;
    int nd, nlow, nbusy;
    set_in(8'h07, 8'h0B, 8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    pulse_send;
    repeat (49) @(posedge CLK);
    #1;
    bus.send = 1'b1;
    @(posedge CLK); #1;
    bus.send = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL clr_pre_overrun got %b exp 1", bus.overrun); end
    repeat (79) @(posedge CLK);
    #1;
    bus.clear = 1'b1; bus.send = 1'b1;
    @(posedge CLK); #1;
    bus.clear = 1'b0; bus.send = 1'b0;
    checks += 4;
    if (bus.tx !== 1'b1) begin errors++; $display("FAIL clr_tx got %b exp 1", bus.tx); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", bus.busy); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %b exp 0", bus.overrun); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL clr_done got %b exp 0", bus.done); end
    nd = 0; nlow = 0; nbusy = 0;
    repeat (300) begin
      @(posedge CLK); #1;
      nd += int'(bus.done); nlow += int'(!bus.tx); nbusy += int'(bus.busy);
    end
    checks += 3;
    if (nd != 0) begin errors++; $display("FAIL clr_done_after got %0d exp 0", nd); end
    if (nlow != 0) begin errors++; $display("FAIL clr_tx_low_after got %0d exp 0", nlow); end
    if (nbusy != 0) begin errors++; $display("FAIL clr_busy_after got %0d exp 0", nbusy); end
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.send = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    test_reset;
    test_basic;
    test_input_change;
    test_overrun;
    test_back_to_back;
    test_random;
    test_async_reset;
    test_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
